// File: rtl/ibex_trace_streamer.sv
// Buffers retired-instruction RVFI records and streams them out as 32-bit words.
// Define IBEX_TRACE_MEM_EN to add memory fields (W4/W5, plus W6 on stores).
module ibex_trace_streamer #(
   parameter int unsigned Depth = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        trace_en_i,
   input  logic        rvfi_valid,
   input  logic [63:0] rvfi_order,
   input  logic [31:0] rvfi_insn,
   input  logic        rvfi_trap,
   input  logic        rvfi_halt,
   input  logic        rvfi_intr,
   input  logic [1:0]  rvfi_mode,
   input  logic [4:0]  rvfi_rd_addr,
   input  logic [31:0] rvfi_rd_wdata,
   input  logic [31:0] rvfi_pc_rdata,
   input  logic [31:0] rvfi_mem_addr,
   input  logic [3:0]  rvfi_mem_rmask,
   input  logic [3:0]  rvfi_mem_wmask,
   input  logic [31:0] rvfi_mem_wdata,
   output logic        trace_valid_o,
   input  logic        trace_ready_i,
   output logic [31:0] trace_data_o,
   output logic        trace_last_o,
   output logic [15:0] drop_count_o
);

   localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;

   typedef enum logic {IDLE, SEND} state_e;

   state_e        r_state;
   logic [2:0]    r_idx;
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_ovf;
   logic [15:0]   r_drops;

   logic [31:0]   r_w0    [Depth];
   logic [31:0]   r_pc    [Depth];
   logic [31:0]   r_insn  [Depth];
   logic [31:0]   r_wdata [Depth];
`ifdef IBEX_TRACE_MEM_EN
   logic [31:0]   r_maddr  [Depth];
   logic [3:0]    r_rmask  [Depth];
   logic [3:0]    r_wmask  [Depth];
   logic [31:0]   r_mwdata [Depth];
`endif

   logic        w_full;
   logic        w_attempt;
   logic        w_accept;
   logic        w_drop;
   logic        w_hs;
   logic        w_pop;
   logic [2:0]  w_len;
   logic [31:0] w_w0;
   logic [31:0] w_data;
   logic        w_unused;

`ifdef IBEX_TRACE_MEM_EN
   assign w_unused = ^rvfi_order[63:16];
   assign w_len    = (r_wmask[r_rd_ptr] != 4'h0) ? 3'd7 : 3'd6;
`else
   assign w_unused = ^{rvfi_order[63:16], rvfi_mem_addr, rvfi_mem_rmask,
                       rvfi_mem_wmask, rvfi_mem_wdata};
   assign w_len    = 3'd4;
`endif

   // Fullness comes from the registered count, so a same-cycle pop never frees a slot.
   assign w_full    = (r_count == (AW+1)'(Depth));
   assign w_attempt = rvfi_valid & trace_en_i;
   assign w_accept  = w_attempt & ~w_full;
   assign w_drop    = w_attempt & w_full;
   assign w_hs      = (r_state == SEND) & trace_ready_i;
   assign w_pop     = w_hs & (r_idx == w_len - 3'd1);
   assign w_w0      = {r_ovf, rvfi_trap, rvfi_halt, rvfi_intr, rvfi_mode,
                       rvfi_rd_addr, 5'b0, rvfi_order[15:0]};

   always_ff @(posedge clk_i) begin
      if (w_accept) begin
         r_w0[r_wr_ptr]    <= w_w0;
         r_pc[r_wr_ptr]    <= rvfi_pc_rdata;
         r_insn[r_wr_ptr]  <= rvfi_insn;
         r_wdata[r_wr_ptr] <= rvfi_rd_wdata;
`ifdef IBEX_TRACE_MEM_EN
         r_maddr[r_wr_ptr]  <= rvfi_mem_addr;
         r_rmask[r_wr_ptr]  <= rvfi_mem_rmask;
         r_wmask[r_wr_ptr]  <= rvfi_mem_wmask;
         r_mwdata[r_wr_ptr] <= rvfi_mem_wdata;
`endif
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_ovf    <= 1'b0;
         r_drops  <= '0;
      end else begin
         r_count <= r_count + (AW+1)'(w_accept) - (AW+1)'(w_pop);
         if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_drop) begin
            r_ovf <= 1'b1;
            if (r_drops != '1) r_drops <= r_drops + 16'd1;
         end else if (w_accept) begin
            r_ovf <= 1'b0;
         end
      end
   end

   // Leaving IDLE on the capture edge itself puts W0 on the bus one cycle after capture.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_idx   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_idx <= '0;
               if ((r_count != '0) || w_accept) r_state <= SEND;
            end
            SEND: begin
               if (w_pop) begin
                  r_idx <= '0;
                  if ((r_count == (AW+1)'(1)) && !w_accept) r_state <= IDLE;
               end else if (w_hs) begin
                  r_idx <= r_idx + 3'd1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_idx   <= '0;
            end
         endcase
      end
   end

   always_comb begin
      w_data = '0;
      if (r_state == SEND) begin
         case (r_idx)
            3'd0: w_data = r_w0[r_rd_ptr];
            3'd1: w_data = r_pc[r_rd_ptr];
            3'd2: w_data = r_insn[r_rd_ptr];
            3'd3: w_data = r_wdata[r_rd_ptr];
`ifdef IBEX_TRACE_MEM_EN
            3'd4: w_data = r_maddr[r_rd_ptr];
            3'd5: w_data = {r_rmask[r_rd_ptr], r_wmask[r_rd_ptr], 24'b0};
            3'd6: w_data = r_mwdata[r_rd_ptr];
`endif
            default: w_data = '0;
         endcase
      end
   end

   assign trace_valid_o = (r_state == SEND);
   assign trace_last_o  = (r_state == SEND) && (r_idx == w_len - 3'd1);
   assign trace_data_o  = w_data;
   assign drop_count_o  = r_drops;

endmodule
